// File: rtl/fifo_pkg.sv
// rtl/fifo_pkg.sv - shared types and constants for the asynchronous FIFO blocks
//
// Contents:
//   FIFO_DATA_WIDTH - default word width shared by memory, write side and read side
//   PREFETCH_DEPTH  - number of words held by the read-side first-word-fall-through stage
//   occ_state_t     - occupancy state of the read-side prefetch buffer
package fifo_pkg;

    localparam int FIFO_DATA_WIDTH = 8;
    localparam int PREFETCH_DEPTH  = 2;

    // Encoding equals the number of buffered words, so the state doubles as occupancy.
    typedef enum logic [1:0] {
        OCC_EMPTY = 2'd0,
        OCC_ONE   = 2'd1,
        OCC_TWO   = 2'd2
    } occ_state_t;

endpackage

// File: rtl/fifo_read_fwft_stage.sv
// rtl/fifo_read_fwft_stage.sv - read-domain first-word-fall-through output stage of the async FIFO
//
// Converts the empty flag / read_enable / 1-cycle-latency RAM interface into a
// valid/ready stream through a 2-entry prefetch buffer (head + spare).
//
// Ports:
//   clock_read        in   read-domain clock
//   read_reset_n      in   asynchronous active-low reset
//   fifo_empty        in   registered empty flag from the read-pointer block
//   fifo_read_enable  out  pop request to the read-pointer block (combinational)
//   mem_read_data     in   RAM output, word addressed in the previous cycle
//   out_valid         out  out_data holds a valid word
//   out_ready         in   consumer accepts the word this cycle
//   out_data          out  head word
//   out_stall_count   out  saturating count of valid & ~ready cycles
//                          (present only when FIFO_READ_STALL_COUNT_EN is defined)
module fifo_read_fwft_stage
    import fifo_pkg::*;
#(
    parameter int DATA_WIDTH = FIFO_DATA_WIDTH
) (
    input  logic                  clock_read,
    input  logic                  read_reset_n,
    input  logic                  fifo_empty,
    output logic                  fifo_read_enable,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data
`ifdef FIFO_READ_STALL_COUNT_EN
    ,
    output logic [15:0]           out_stall_count
`endif
);

    occ_state_t            state;
    occ_state_t            state_next;
    logic                  inflight;
    logic                  arrive;
    logic                  pop;
    logic [1:0]            occ_sum;
    logic [DATA_WIDTH-1:0] head;
    logic [DATA_WIDTH-1:0] spare;

    // A request issued last cycle means mem_read_data carries a word now.
    assign arrive   = inflight;
    assign out_data = head;

    always_ff @(posedge clock_read or negedge read_reset_n) begin
        if (!read_reset_n) begin
            state    <= OCC_EMPTY;
            inflight <= 1'b0;
        end else begin
            state    <= state_next;
            inflight <= fifo_read_enable;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            OCC_EMPTY: begin
                if (arrive) begin
                    state_next = OCC_ONE;
                end
            end
            OCC_ONE: begin
                if (arrive && !pop) begin
                    state_next = OCC_TWO;
                end else if (!arrive && pop) begin
                    state_next = OCC_EMPTY;
                end
            end
            OCC_TWO: begin
                if (pop) begin
                    state_next = OCC_ONE;
                end
            end
            default: state_next = OCC_EMPTY;
        endcase
    end

    // Issue only when the word is guaranteed a slot: buffered plus in-flight
    // words below capacity, or a pop this cycle frees the slot it will land in.
    always_comb begin
        out_valid        = (state != OCC_EMPTY);
        pop              = out_valid && out_ready;
        occ_sum          = 2'(state) + {1'b0, inflight};
        fifo_read_enable = !fifo_empty && ((occ_sum < 2'(PREFETCH_DEPTH)) || pop);
    end

    // Head is always the oldest word; spare is only filled while head is held.
    always_ff @(posedge clock_read or negedge read_reset_n) begin
        if (!read_reset_n) begin
            head  <= '0;
            spare <= '0;
        end else begin
            case (state)
                OCC_EMPTY: begin
                    if (arrive) begin
                        head <= mem_read_data;
                    end
                end
                OCC_ONE: begin
                    if (arrive && pop) begin
                        head <= mem_read_data;
                    end else if (arrive) begin
                        spare <= mem_read_data;
                    end
                end
                OCC_TWO: begin
                    if (pop) begin
                        head <= spare;
                    end
                end
                default: ;
            endcase
        end
    end

`ifdef FIFO_READ_STALL_COUNT_EN
    always_ff @(posedge clock_read or negedge read_reset_n) begin
        if (!read_reset_n) begin
            out_stall_count <= '0;
        end else if (out_valid && !out_ready && (out_stall_count != 16'hFFFF)) begin
            out_stall_count <= out_stall_count + 16'd1;
        end
    end
`endif

    a_no_read_when_empty: assert property (
        @(posedge clock_read) disable iff (!read_reset_n)
        !(fifo_read_enable && fifo_empty)
    ) else $error("fifo_read_enable asserted while fifo_empty");

    a_no_arrival_when_full: assert property (
        @(posedge clock_read) disable iff (!read_reset_n)
        !((state == OCC_TWO) && arrive)
    ) else $fatal(1, "RAM word arrived with prefetch buffer full");

endmodule

// File: doc/fifo_read_fwft_stage.md
Name: fifo_read_fwft_stage

Overview:
- Read-domain output stage of the asynchronous FIFO, directly downstream of the read-pointer/empty block and the dual-port RAM read port.
- Turns "empty flag + read_enable + 1-cycle-latency synchronous RAM data" into a first-word-fall-through valid/ready stream.
- 2-entry prefetch buffer sustains one word per cycle while the consumer accepts.
- Drives the FIFO read_enable; never pops the FIFO unless buffer space is guaranteed.

Parameters:
- DATA_WIDTH, 8, width of FIFO words and out_data.

Ports:
- clock_read  in  1  read-domain clock.
- read_reset_n  in  1  reset; asynchronous, active-low.
- fifo_empty  in  1  registered empty flag from the read-pointer block.
- fifo_read_enable  out  1  pop request to the read-pointer block (combinational).
- mem_read_data  in  DATA_WIDTH  synchronous RAM output; holds the word addressed in the previous cycle.
- out_valid  out  1  out_data holds a valid word.
- out_ready  in  1  consumer accepts the word this cycle.
- out_data  out  DATA_WIDTH  head word.
- (feature) out_stall_count  out  16  see Optional Feature.

Behaviour:
- Reset state, asynchronous on read_reset_n low: out_valid=0, out_data=0, spare register=0, inflight=0, occupancy=0. Any in-flight RAM word is discarded; the pointer block resets on the same reset, so the two stay consistent.
- pop = out_valid & out_ready.
- fifo_read_enable = ~fifo_empty & ((occupancy + inflight < 2) | pop).
- inflight is registered: inflight <= fifo_read_enable.
- Latency: a word requested in cycle t is captured at the end of cycle t+1 and is visible on out_data in cycle t+2. With a fresh write visible through fifo_empty, first out_valid appears 2 cycles after fifo_empty falls.
- Occupancy FSM:
  - States: EMPTY(0), ONE(1), TWO(2).
  - arrive = inflight (mem_read_data is valid this cycle).
  - EMPTY: arrive -> ONE, word loaded into the head.
  - ONE: arrive & ~pop -> TWO, word loaded into the spare.
  - ONE: arrive & pop -> ONE, word loaded into the head.
  - ONE: ~arrive & pop -> EMPTY.
  - TWO: pop -> ONE, spare moves to the head. An arrival in TWO cannot occur because the issue rule forbids it. Any arrive & pop in TWO is a fatal assertion error.
- Ordering: strict FIFO order is preserved. The head is always the oldest word; the spare is only ever newer than the head.
- out_valid = (state != EMPTY). out_data is driven from the head register and is stable while out_valid & ~out_ready.
- Throughput: with fifo_empty=0 continuously and out_ready=1, exactly one word is delivered per cycle after the 2-cycle fill.
- Boundaries:
  - fifo_empty rises with a request in flight: the in-flight word is still accepted. No further requests are issued.
  - out_ready high while out_valid=0 has no effect.
  - Simultaneous arrive & pop in ONE: the new word replaces the head in the same edge; there is no bubble.
  - Reset mid-stream: all buffered and in-flight words are lost; out_valid drops immediately (asynchronous).
- fifo_read_enable must never be asserted while fifo_empty=1. This is enforced by assertion.

Optional Feature:
- Macro FIFO_READ_STALL_COUNT_EN.
- Defined: adds output out_stall_count[15:0].
  - Increments on every cycle with out_valid & ~out_ready.
  - Saturates at 16'hFFFF.
  - Reset to 0 by read_reset_n.
- Undefined: the port and counter are absent; functional behaviour is otherwise identical.

Decomposition:
- Shared package fifo_pkg:
  - occupancy state enum (OCC_EMPTY, OCC_ONE, OCC_TWO).
  - constant PREFETCH_DEPTH=2.
  - default FIFO data width, shared with the memory and write-side blocks.
- No sub-module. The buffer and FSM are a single module.
- The stall counter is an inline ifdef block.

Test Plan:
- Reset with fifo_empty=1 -> out_valid=0, out_data=0, fifo_read_enable=0; all three hold for 10 cycles.
- Preload 5 words 0x11..0x15, out_ready=1 -> fifo_read_enable high for 5 cycles; out_data=0x11..0x15 on consecutive cycles starting 2 cycles after the first request, with no bubbles.
- Preload 8 words, out_ready=0 -> exactly 2 requests issued, out_valid=1, out_data=0x11 held. Then out_ready=1 -> remaining 6 words fetched and all 8 delivered in order.
- Alternate out_ready 1/0 over 20 words -> no loss, no duplication, order preserved; fifo_read_enable never high while fifo_empty=1.
- Assert read_reset_n low with 2 words buffered and 1 in flight -> out_valid=0 asynchronously. After release, no stale word appears.
- With FIFO_READ_STALL_COUNT_EN defined, hold out_ready=0 with valid data for 70000 cycles -> out_stall_count=16'hFFFF and holds.
